// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 encodings, FSM state type and lane-mask helper for lsu_bram
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  // Lanes touched by an access, rotated so bytes spilling past lane 3 wrap to lane 0.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] size_mask;
    logic [7:0] wide;
    case (funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    wide = {4'b0000, size_mask} << off;
    return wide[3:0] | wide[7:4];
  endfunction

endpackage

// File: rtl/bram_lane.sv
// rtl/bram_lane.sv - one byte-wide bank, single synchronous read/write port, registered read data
module bram_lane #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/lsu_bram.sv
// rtl/lsu_bram.sv - RV32 load/store data memory over four byte banks; LSU_BRAM_MISALIGNED_EN enables split word-crossing accesses
module lsu_bram
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int WW = ADDR_WIDTH - 2;

  logic [1:0]    req_off;
  logic [WW-1:0] req_word;
  logic          accept, req_legal, req_cross, req_err;
  logic [3:0]    req_mask, first_mask;
  logic [63:0]   wdata_dbl;
  logic [31:0]   wdata_rot;

  logic [WW-1:0] bank_addr;
  logic [3:0]    bank_we;
  logic [31:0]   bank_wdata, bank_q;

  logic          err_q, load_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [31:0]   merged, dbl_shift_src, aligned, ext;
  logic [63:0]   rdata_dbl;

  assign req_off  = req_addr[1:0];
  assign req_word = req_addr[ADDR_WIDTH-1:2];

  always_comb begin
    req_legal = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: req_legal = 1'b1;
      F3_BU, F3_HU:     req_legal = ~req_write;
      default:          req_legal = 1'b0;
    endcase
  end

  assign req_cross = (req_funct3[1:0] == 2'b01 && req_off == 2'b11) ||
                     (req_funct3[1:0] == 2'b10 && req_off != 2'b00);

`ifdef LSU_BRAM_MISALIGNED_EN
  assign req_err = ~req_legal;
`else
  assign req_err = ~req_legal | req_cross;
`endif

  assign req_mask   = lane_mask(req_funct3, req_off);
  assign first_mask = req_mask & (4'hF << req_off);
  // Store data rotated so byte k lands on lane (addr+k)[1:0].
  assign wdata_dbl  = {req_wdata, req_wdata} << {req_off, 3'b000};
  assign wdata_rot  = wdata_dbl[63:32];
  assign accept     = req_valid & req_ready & ~reset;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    bram_lane #(.AW(WW)) u_lane (
      .clk   (clk),
      .we    (bank_we[l]),
      .addr  (bank_addr),
      .wdata (bank_wdata[8*l +: 8]),
      .rdata (bank_q[8*l +: 8])
    );
  end

`ifdef LSU_BRAM_MISALIGNED_EN
  state_t        state;
  logic [WW-1:0] sec_word;
  logic [3:0]    sec_we, hold_sel, second_mask;
  logic [31:0]   sec_wdata, hold;

  assign second_mask = req_mask & ~first_mask;

  always_comb begin
    bank_addr  = req_word;
    bank_we    = 4'b0000;
    bank_wdata = wdata_rot;
    if (state == SECOND) begin
      bank_addr  = sec_word;
      bank_we    = sec_we;
      bank_wdata = sec_wdata;
    end else if (accept && req_write && !req_err) begin
      bank_we = first_mask;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      err_q     <= 1'b0;
      load_q    <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      sec_word  <= '0;
      sec_we    <= 4'b0000;
      sec_wdata <= 32'h0;
      hold_sel  <= 4'b0000;
      hold      <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            err_q    <= req_err;
            load_q   <= ~req_write & ~req_err;
            f3_q     <= req_funct3;
            off_q    <= req_off;
            hold_sel <= 4'b0000;
            if (req_cross && !req_err) begin
              state     <= SECOND;
              req_ready <= 1'b0;
              sec_word  <= req_word + 1'b1;
              sec_we    <= req_write ? second_mask : 4'b0000;
              sec_wdata <= wdata_rot;
              hold_sel  <= first_mask;
            end else begin
              rsp_valid <= 1'b1;
            end
          end
        end
        SECOND: begin
          // Bank output here is still word N, read at acceptance.
          hold      <= bank_q;
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    merged = bank_q;
    for (int l = 0; l < 4; l++)
      if (hold_sel[l]) merged[8*l +: 8] = hold[8*l +: 8];
  end
`else
  assign req_ready = 1'b1;

  always_comb begin
    bank_addr  = req_word;
    bank_wdata = wdata_rot;
    bank_we    = (accept && req_write && !req_err) ? first_mask : 4'b0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      err_q     <= 1'b0;
      load_q    <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        err_q  <= req_err;
        load_q <= ~req_write & ~req_err;
        f3_q   <= req_funct3;
        off_q  <= req_off;
      end
    end
  end

  assign merged = bank_q;
`endif

  assign dbl_shift_src = merged;
  assign rdata_dbl     = {dbl_shift_src, dbl_shift_src} >> {off_q, 3'b000};
  assign aligned       = rdata_dbl[31:0];

  always_comb begin
    ext = 32'h0;
    case (f3_q)
      F3_B:    ext = {{24{aligned[7]}}, aligned[7:0]};
      F3_H:    ext = {{16{aligned[15]}}, aligned[15:0]};
      F3_W:    ext = aligned;
      F3_BU:   ext = {24'h0, aligned[7:0]};
      F3_HU:   ext = {16'h0, aligned[15:0]};
      default: ext = 32'h0;
    endcase
  end

  assign rsp_rdata = (rsp_valid && load_q) ? ext : 32'h0;
  assign rsp_err   = rsp_valid & err_q;

endmodule
